// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : controller states (IDLE, RUN, DONE)
package sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sub_pkg

// File: rtl/full_sub_cell.sv
// Single-bit full subtractor computing a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d         : difference bit
//   bo        : borrow-out
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (b & bin) | (~a & bin);

endmodule : full_sub_cell

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per
// clock, LSB first. Operands are captured when start is accepted in IDLE;
// results, borrow-out, signed overflow and zero flag are registered on the
// final bit and held until the next completion or reset.
//   clk, rst       : clock, synchronous active-high reset
//   start          : request an operation (honoured in IDLE only)
//   a, b, bin      : minuend, subtrahend, borrow-in
//   busy           : high while the bits are being processed
//   done           : one-cycle pulse when results become valid
//   diff, bout     : difference and final borrow-out
//   ovf, zero      : two's-complement overflow, diff == 0
//
// state | meaning
// IDLE  | waiting for start
// RUN   | processing one bit per cycle, LSB first
// DONE  | results valid, done pulse high
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_d;
    logic               r_br;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;
    logic               r_zero;

    logic               w_d;
    logic               w_bo;
    logic [WIDTH-1:0]   w_d_next;
    logic               w_ovf;

    full_sub_cell u_cell (
        .a   (r_a[0]),
        .b   (r_b[0]),
        .bin (r_br),
        .d   (w_d),
        .bo  (w_bo)
    );

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign w_d_next = {w_d, r_d[WIDTH-1:1]};

    // On the last bit r_a[0]/r_b[0] hold the original operand MSBs and w_d is
    // the result MSB.
    assign w_ovf = (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_br    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_d     <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a  <= r_a >> 1;
                    r_b  <= r_b >> 1;
                    r_br <= w_bo;
                    r_d  <= w_d_next;
                    if (r_cnt == LAST_BIT) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_diff  <= w_d_next;
                        r_bout  <= w_bo;
                        r_ovf   <= w_ovf;
                        r_zero  <= (w_d_next == '0);
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule : serial_subtractor
